chacha_stream_xor: RTL and testbench

Keystream consumer for the ChaCha20 core: accepts 512-bit pads on an Avalon-ST sink and XORs them, word by word, with 32-bit data words written over an Avalon-MM slave. The results are queued in a word FIFO for the CPU (Nios II / ARM) to read back. It sits between the ChaCha20 generator's stream source and the processor bus, completing encrypt/decrypt without software XOR. Two pad slots (active + prefetch) hide the generator's 20-cycle round latency.

---
 rtl/chacha_pkg.sv | 30 +++
 rtl/chacha_stream_xor_if.sv | 24 ++
 rtl/chacha_stream_xor_word_fifo.sv | 51 +++++
 rtl/chacha_stream_xor.sv | 98 +++++++++
 tb/tb_chacha_stream_xor.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/chacha_pkg.sv
// Types and constants shared by the ChaCha20 core and its keystream consumers.
package chacha_pkg;
    typedef logic [31:0]  Word_t;
    typedef Word_t [15:0] State_t;
    typedef logic [511:0] RawState_t;

    localparam int ROUND_COUNT = 20;
    localparam int BCOUNT_IDX  = 12;

    typedef enum logic [1:0] {
        CSR_DATA    = 2'd0,
        CSR_STATUS  = 2'd1,
        CSR_CONTROL = 2'd2
    } CsrAddr_t;

    // Word i of a block travels on bits [32*i +: 32] of the raw stream bus.
    function automatic RawState_t ToRawState(input State_t s);
        RawState_t r;
        r = '0;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = s[i];
        return r;
    endfunction

    function automatic State_t FromRawState(input RawState_t r);
        State_t s;
        s = '0;
        for (int i = 0; i < 16; i++) s[i] = r[32*i +: 32];
        return s;
    endfunction
endpackage

// File: rtl/chacha_stream_xor_if.sv
// Avalon-MM CSR port plus Avalon-ST pad sink between the CPU, the generator and the XOR block.
interface chacha_stream_xor_if;
    import chacha_pkg::*;

    logic      csr_write;
    logic      csr_read;
    logic [1:0] csr_address;
    Word_t     csr_writedata;
    Word_t     csr_readdata;
    logic      csr_waitrequest;
    RawState_t st_data;
    logic      st_valid;
    logic      st_ready;

    modport slave (
        input  csr_write, csr_read, csr_address, csr_writedata, st_data, st_valid,
        output csr_readdata, csr_waitrequest, st_ready
    );

    modport master (
        output csr_write, csr_read, csr_address, csr_writedata, st_data, st_valid,
        input  csr_readdata, csr_waitrequest, st_ready
    );
endinterface

// File: rtl/chacha_stream_xor_word_fifo.sv
// Show-ahead word FIFO with synchronous flush and occupancy count.
module word_fifo
    import chacha_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  Word_t                  i_data,
    input  logic                   i_pop,
    output Word_t                  o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    Word_t          r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           w_push_ok;
    logic           w_pop_ok;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    always_ff @(posedge clock) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
        end
    end
endmodule

// File: rtl/chacha_stream_xor.sv
// XORs CPU-written words with ChaCha20 keystream pads (active + prefetch slot) into a result FIFO.
module chacha_stream_xor
    import chacha_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    chacha_stream_xor_if.slave   bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    State_t          r_act;
    State_t          r_pf;
    logic            r_act_v;
    logic            r_pf_v;
    logic [3:0]      r_idx;

    logic            w_flush;
    logic            w_data_wr;
    logic            w_data_rd;
    logic            w_wr_acc;
    logic            w_rd_acc;
    logic            w_last;
    logic            w_beat;
    logic            w_act_free;
    Word_t           w_xor;
    Word_t           w_head;
    Word_t           w_status;
    State_t          w_beat_pad;
    logic [CW-1:0]   w_count;
    logic            w_full;
    logic            w_empty;

    assign w_flush    = bus.csr_write && (bus.csr_address == CSR_CONTROL) && bus.csr_writedata[0];
    assign w_data_wr  = bus.csr_write && (bus.csr_address == CSR_DATA);
    assign w_data_rd  = bus.csr_read && !bus.csr_write && (bus.csr_address == CSR_DATA);
    assign w_wr_acc   = w_data_wr && r_act_v && !w_full;
    assign w_rd_acc   = w_data_rd && !w_empty;
    assign w_last     = w_wr_acc && (r_idx == 4'd15);
    assign w_beat     = bus.st_valid && bus.st_ready;
    // A beat may land straight in act when the last word of a lone pad is consumed this cycle.
    assign w_act_free = !r_act_v || (w_last && !r_pf_v);
    assign w_xor      = bus.csr_writedata ^ r_act[r_idx];
    assign w_beat_pad = FromRawState(bus.st_data);
    assign w_status   = {19'd0, r_pf_v, r_act_v, r_idx, 7'(w_count)};

    assign bus.st_ready        = !r_pf_v && !reset && !w_flush;
    assign bus.csr_waitrequest = (w_data_wr && !w_wr_acc) || (w_data_rd && w_empty);

    always_comb begin
        bus.csr_readdata = '0;
        if (bus.csr_read && !bus.csr_write) begin
            case (bus.csr_address)
                CSR_DATA:   if (!w_empty) bus.csr_readdata = w_head;
                CSR_STATUS: bus.csr_readdata = w_status;
                default:    bus.csr_readdata = '0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset || w_flush) begin
            r_act_v <= 1'b0;
            r_pf_v  <= 1'b0;
            r_idx   <= '0;
        end else begin
            if (w_wr_acc) r_idx <= r_idx + 4'd1;
            if (w_beat && w_act_free) begin
                r_act   <= w_beat_pad;
                r_act_v <= 1'b1;
                r_idx   <= '0;
            end else if (w_last && r_pf_v) begin
                r_act  <= r_pf;
                r_pf_v <= 1'b0;
            end else if (w_last) begin
                r_act_v <= 1'b0;
            end
            if (w_beat && !w_act_free) begin
                r_pf   <= w_beat_pad;
                r_pf_v <= 1'b1;
            end
        end
    end

    word_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_flush (w_flush),
        .i_push  (w_wr_acc),
        .i_data  (w_xor),
        .i_pop   (w_rd_acc),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
endmodule

// File: tb/tb_chacha_stream_xor.sv
// Directed bench for chacha_stream_xor: queue-based reference model checked every cycle plus literal checks.
module tb_chacha_stream_xor;
    import chacha_pkg::*;

    localparam int DEPTH = 16;
    localparam int BUDGET = 200;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    chacha_stream_xor_if bus();

    chacha_stream_xor #(.DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expired(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: still stalled after %0d cycles, expected completion", name, BUDGET);
    endtask

    function automatic RawState_t pad_lin();
        RawState_t p;
        for (int i = 0; i < 16; i++) p[32*i +: 32] = 32'h01010101 * 32'(i);
        return p;
    endfunction

    function automatic RawState_t pad_a5();
        RawState_t p;
        for (int i = 0; i < 16; i++) p[32*i +: 32] = 32'hA5A5A5A5 + 32'(i);
        return p;
    endfunction

    // Reference model: queued pads (front = active), word index, queued results.
    RawState_t m_pads[$];
    Word_t     m_res[$];
    int        m_idx = 0;

    function automatic Word_t m_status();
        return {19'd0, m_pads.size() == 2, m_pads.size() >= 1, 4'(m_idx), 7'(m_res.size())};
    endfunction

    always @(posedge clock) begin
        logic      flush, wr, rd, beat;
        RawState_t cur;
        flush = bus.csr_write && bus.csr_address == 2'd2 && bus.csr_writedata[0];
        if (reset || flush) begin
            m_pads.delete();
            m_res.delete();
            m_idx = 0;
        end else begin
            wr   = bus.csr_write && bus.csr_address == 2'd0 && m_pads.size() > 0 && m_res.size() < DEPTH;
            rd   = bus.csr_read && !bus.csr_write && bus.csr_address == 2'd0 && m_res.size() > 0;
            beat = bus.st_valid && m_pads.size() < 2;
            if (rd) void'(m_res.pop_front());
            if (wr) begin
                cur = m_pads[0];
                m_res.push_back(bus.csr_writedata ^ cur[32*m_idx +: 32]);
                m_idx++;
                if (m_idx == 16) begin
                    m_idx = 0;
                    void'(m_pads.pop_front());
                end
            end
            if (beat) m_pads.push_back(bus.st_data);
        end
    end

    always @(negedge clock) begin
        logic flush, dw, dr, exp_wait;
        flush = bus.csr_write && bus.csr_address == 2'd2 && bus.csr_writedata[0];
        check("st_ready", 32'(bus.st_ready), 32'(!reset && !flush && m_pads.size() < 2));
        if (reset) begin
            check("rst_readdata", bus.csr_readdata, 32'd0);
        end else begin
            dw = bus.csr_write && bus.csr_address == 2'd0;
            dr = bus.csr_read && !bus.csr_write && bus.csr_address == 2'd0;
            exp_wait = (dw && (m_pads.size() == 0 || m_res.size() == DEPTH)) || (dr && m_res.size() == 0);
            check("waitrequest", 32'(bus.csr_waitrequest), 32'(exp_wait));
            if (bus.csr_read && !bus.csr_write) begin
                case (bus.csr_address)
                    2'd0:    if (m_res.size() > 0) check("rd_data", bus.csr_readdata, m_res[0]);
                    2'd1:    check("rd_status", bus.csr_readdata, m_status());
                    default: check("rd_zero", bus.csr_readdata, 32'd0);
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic bus_wr(input logic [1:0] a, input Word_t d);
        int n = 0;
        bus.csr_write = 1'b1;
        bus.csr_address = a;
        bus.csr_writedata = d;
        @(negedge clock);
        while (bus.csr_waitrequest && n < BUDGET) begin
            @(negedge clock);
            n++;
        end
        if (n >= BUDGET) expired("bus_wr");
        tick();
        bus.csr_write = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output Word_t d);
        int n = 0;
        bus.csr_read = 1'b1;
        bus.csr_address = a;
        @(negedge clock);
        while (bus.csr_waitrequest && n < BUDGET) begin
            @(negedge clock);
            n++;
        end
        if (n >= BUDGET) expired("bus_rd");
        d = bus.csr_readdata;
        tick();
        bus.csr_read = 1'b0;
    endtask

    task automatic send_pad(input RawState_t p);
        int n = 0;
        bus.st_valid = 1'b1;
        bus.st_data = p;
        @(negedge clock);
        while (!bus.st_ready && n < BUDGET) begin
            @(negedge clock);
            n++;
        end
        if (n >= BUDGET) expired("send_pad");
        tick();
        bus.st_valid = 1'b0;
    endtask

    task automatic wr_nostall(input Word_t d, input int j);
        bus.csr_write = 1'b1;
        bus.csr_address = 2'd0;
        bus.csr_writedata = d;
        @(negedge clock);
        check("t3_no_stall", 32'(bus.csr_waitrequest), 32'd0);
        if (j == 7) check("t3_ready_before_promo", 32'(bus.st_ready), 32'd0);
        if (j == 8) check("t3_ready_after_promo", 32'(bus.st_ready), 32'd1);
        tick();
        bus.csr_write = 1'b0;
    endtask

    function automatic Word_t t3_exp(input int k);
        return (k < 16) ? 32'h01010101 * 32'(k) : 32'hA5A5A5A5 + 32'(k - 16);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Word_t v;
        bus.csr_write = 1'b0;
        bus.csr_read = 1'b0;
        bus.csr_address = 2'd0;
        bus.csr_writedata = '0;
        bus.st_data = '0;
        bus.st_valid = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clock);
        check("ready_after_reset", 32'(bus.st_ready), 32'd1);
        tick();
        bus_rd(2'd1, v);
        check("status_reset", v, 32'd0);

        // Single pad, 16 inverted words.
        send_pad(pad_lin());
        for (int i = 0; i < 16; i++) bus_wr(2'd0, 32'hFFFFFFFF);
        for (int i = 0; i < 16; i++) begin
            bus_rd(2'd0, v);
            check("t1_rd", v, ~(32'h01010101 * 32'(i)));
        end
        bus_rd(2'd1, v);
        check("t1_status", v, 32'd0);

        // Write issued with no pad loaded.
        bus.csr_write = 1'b1;
        bus.csr_address = 2'd0;
        bus.csr_writedata = 32'h12345678;
        repeat (3) begin
            @(negedge clock);
            check("t2_stall", 32'(bus.csr_waitrequest), 32'd1);
        end
        bus.st_valid = 1'b1;
        bus.st_data = pad_a5();
        tick();
        bus.st_valid = 1'b0;
        @(negedge clock);
        check("t2_accept", 32'(bus.csr_waitrequest), 32'd0);
        tick();
        bus.csr_write = 1'b0;
        bus_rd(2'd0, v);
        check("t2_data", v, 32'hB791F3DD);
        bus_wr(2'd2, 32'd1);

        // Two pads back-to-back, boundary crossed inside a write burst.
        bus.st_valid = 1'b1;
        bus.st_data = pad_lin();
        tick();
        bus.st_data = pad_a5();
        tick();
        bus.st_valid = 1'b0;
        @(negedge clock);
        check("t3_ready_pf_full", 32'(bus.st_ready), 32'd0);
        tick();
        for (int j = 0; j < 8; j++) wr_nostall(32'd0, -1);
        for (int k = 0; k < 8; k++) begin
            bus_rd(2'd0, v);
            check("t3_rd", v, t3_exp(k));
        end
        for (int j = 0; j < 16; j++) wr_nostall(32'd0, j);
        for (int k = 8; k < 24; k++) begin
            bus_rd(2'd0, v);
            check("t3_rd", v, t3_exp(k));
        end
        for (int j = 0; j < 8; j++) wr_nostall(32'd0, -1);
        for (int k = 24; k < 32; k++) begin
            bus_rd(2'd0, v);
            check("t3_rd", v, t3_exp(k));
        end
        bus_rd(2'd1, v);
        check("t3_status", v, 32'd0);

        // FIFO full.
        send_pad(pad_lin());
        send_pad(pad_a5());
        for (int i = 0; i < DEPTH; i++) bus_wr(2'd0, 32'(i));
        bus_rd(2'd1, v);
        check("t4_status_full", v, 32'h00000810);
        bus.csr_write = 1'b1;
        bus.csr_address = 2'd0;
        bus.csr_writedata = 32'hCAFEF00D;
        repeat (3) begin
            @(negedge clock);
            check("t4_full_stall", 32'(bus.csr_waitrequest), 32'd1);
        end
        tick();
        bus.csr_write = 1'b0;
        bus_rd(2'd0, v);
        check("t4_head", v, 32'd0);
        bus.csr_write = 1'b1;
        bus.csr_writedata = 32'hCAFEF00D;
        @(negedge clock);
        check("t4_resume", 32'(bus.csr_waitrequest), 32'd0);
        tick();
        bus.csr_write = 1'b0;
        bus_wr(2'd2, 32'd1);

        // Flush mid-pad with a beat offered.
        send_pad(pad_lin());
        send_pad(pad_a5());
        for (int i = 0; i < 5; i++) bus_wr(2'd0, 32'(i));
        bus_rd(2'd1, v);
        check("t5_status_mid", v, 32'h00001A85);
        bus.st_valid = 1'b1;
        bus.st_data = pad_lin();
        bus.csr_write = 1'b1;
        bus.csr_address = 2'd2;
        bus.csr_writedata = 32'hFFFF0001;
        @(negedge clock);
        check("t5_ready_flush", 32'(bus.st_ready), 32'd0);
        tick();
        bus.csr_write = 1'b0;
        bus.st_valid = 1'b0;
        @(negedge clock);
        check("t5_ready_after", 32'(bus.st_ready), 32'd1);
        tick();
        bus_rd(2'd1, v);
        check("t5_status_flushed", v, 32'd0);

        // Reset mid-stream.
        send_pad(pad_lin());
        for (int i = 0; i < 3; i++) bus_wr(2'd0, 32'hFFFF0000 + 32'(i));
        bus_rd(2'd1, v);
        check("t6_status_pre", v, 32'h00000983);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("t6_ready", 32'(bus.st_ready), 32'd1);
        tick();
        bus_rd(2'd1, v);
        check("t6_status", v, 32'd0);
        bus.csr_read = 1'b1;
        bus.csr_address = 2'd0;
        repeat (3) begin
            @(negedge clock);
            check("t6_rd_stall", 32'(bus.csr_waitrequest), 32'd1);
        end
        tick();
        bus.csr_read = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
